// File: rtl/ir_fetch_seq_pkg.sv
// Shared opcode constants and state encodings for the t5 instruction register.
package ir_fetch_seq_pkg;

  localparam logic [2:0] CU_ADD        = 3'd0;
  localparam logic [2:0] CU_SUB        = 3'd1;
  localparam logic [2:0] CU_LDA        = 3'd2;
  localparam logic [2:0] CU_JMP        = 3'd3;
  localparam logic [2:0] CU_BAN        = 3'd4;
  localparam logic [2:0] CU_LONG_BEGIN = 3'd7;

  // Every short opcode from add through ban decodes; the rest are illegal.
  localparam logic [7:0] CU_LEGAL_MASK = (8'd1 << CU_ADD) | (8'd1 << CU_SUB) |
                                         (8'd1 << CU_LDA) | (8'd1 << CU_JMP) |
                                         (8'd1 << CU_BAN);

  localparam logic [1:0] IRS_IDLE = 2'd0;
  localparam logic [1:0] IRS_EXT  = 2'd1;
  localparam logic [1:0] IRS_HOLD = 2'd2;

endpackage

// File: rtl/ir_fetch_seq_ext_shift.sv
// Extension-byte counter plus the shift that appends each byte below the
// bytes already collected, so the first extension byte lands most significant.
module ir_fetch_seq_ext_shift #(
  parameter int DATA_W    = 8,
  parameter int EXT_BYTES = 1,
  localparam int AD_W     = EXT_BYTES * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  input  logic [AD_W-1:0]   cur,
  output logic [AD_W-1:0]   shifted,
  output logic              done
);

  localparam int CNT_W = $clog2(EXT_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(EXT_BYTES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (shift) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = shift && (cnt_q == LAST);

  generate
    if (AD_W == DATA_W) begin : g_single
      logic cur_unused;
      assign cur_unused = ^cur;
      assign shifted    = din;
    end else begin : g_multi
      assign shifted = {cur[AD_W-DATA_W-1:0], din};
    end
  endgenerate

endmodule

// File: rtl/ir_fetch_seq.sv
// Instruction register: decodes short opcodes from one byte, assembles long
// instructions from an opcode byte plus extension bytes, holds op/ad for the CU.
module ir_fetch_seq
  import ir_fetch_seq_pkg::*;
#(
  parameter int                    DATA_W     = 8,
  parameter int                    OPC_W      = 3,
  parameter int                    EXT_BYTES  = 1,
  parameter logic [OPC_W-1:0]      LONG_CODE  = CU_LONG_BEGIN,
  parameter logic [2**OPC_W-1:0]   LEGAL_MASK = CU_LEGAL_MASK,
  localparam int                   AD_W       = EXT_BYTES * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] op,
  output logic [AD_W-1:0]   ad,
  output logic              is_long,
  output logic              illegal,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int LOW_W = DATA_W - OPC_W;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] op_q, op_d;
  logic [AD_W-1:0]   ad_q, ad_d;
  logic              is_long_q, is_long_d;
  logic              illegal_q, illegal_d;
  logic              out_valid_q, out_valid_d;

  logic [OPC_W-1:0]  opc;
  logic              accept, decode_first, ext_clear, ext_shift, ext_done;
  logic [AD_W-1:0]   ext_ad;

  assign opc = in_data[DATA_W-1 -: OPC_W];

  // Both ports are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender holds data stable while valid && !ready.
  // HOLD passes out_ready straight through so a new byte can replace a
  // consumed result on the same edge.
  assign in_ready = !flush && ((state_q == IRS_IDLE) || (state_q == IRS_EXT) ||
                               ((state_q == IRS_HOLD) && out_ready));
  assign accept       = in_valid && in_ready;
  assign decode_first = accept && ((state_q == IRS_IDLE) || (state_q == IRS_HOLD));
  assign ext_shift    = accept && (state_q == IRS_EXT);
  assign ext_clear    = flush || (decode_first && (opc == LONG_CODE));

  ir_fetch_seq_ext_shift #(
    .DATA_W   (DATA_W),
    .EXT_BYTES(EXT_BYTES)
  ) u_ext (
    .clk    (clk),
    .rst    (rst),
    .clear  (ext_clear),
    .shift  (ext_shift),
    .din    (in_data),
    .cur    (ad_q),
    .shifted(ext_ad),
    .done   (ext_done)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ad_d        = ad_q;
    is_long_d   = is_long_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = IRS_IDLE;
      op_d        = '0;
      ad_d        = '0;
      is_long_d   = 1'b0;
      illegal_d   = 1'b0;
      out_valid_d = 1'b0;
    end else if (decode_first) begin
      is_long_d = 1'b0;
      if (opc == LONG_CODE) begin
        op_d        = in_data;
        ad_d        = '0;
        illegal_d   = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IRS_EXT;
      end else begin
        op_d        = {opc, {LOW_W{1'b0}}};
        ad_d        = LEGAL_MASK[opc] ? AD_W'(in_data[LOW_W-1:0]) : '0;
        illegal_d   = !LEGAL_MASK[opc];
        out_valid_d = 1'b1;
        state_d     = IRS_HOLD;
      end
    end else if (ext_shift) begin
      ad_d = ext_ad;
      if (ext_done) begin
        is_long_d   = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IRS_HOLD;
      end
    end else if ((state_q == IRS_HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IRS_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IRS_IDLE;
      op_q        <= '0;
      ad_q        <= '0;
      is_long_q   <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ad_q        <= ad_d;
      is_long_q   <= is_long_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign op        = op_q;
  assign ad        = ad_q;
  assign is_long   = is_long_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/ir_fetch_seq.md
Name: ir_fetch_seq

Overview:
- Sequential, parametrised instruction register for the t5 accumulator CPU.
- Accepts instruction bytes from the fetch path over a valid/ready handshake.
- Decodes short instructions from one byte. Assembles long instructions from an opcode byte plus EXT_BYTES extension bytes.
- Presents a registered op/ad pair to the control unit over a second valid/ready handshake.

Parameters:
DATA_W, 8, instruction byte width
OPC_W, 3, opcode field width (top bits of byte)
EXT_BYTES, 1, extension bytes following a long-opcode byte (>=1)
LONG_CODE, 3'b111, opcode field value marking a long instruction (`cu_long_begin)
LEGAL_MASK, 8'b0001_1111, bit i set = short opcode i legal (`cu_add..`cu_ban)
AD_W, EXT_BYTES*DATA_W, address output width (derived; must be >= DATA_W-OPC_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  DATA_W  instruction byte from fetch
in_valid  in  1  in_data valid
in_ready  out  1  byte accepted when in_valid && in_ready
flush  in  1  synchronous abort (jmp/ban taken)
op  out  DATA_W  decoded opcode
ad  out  AD_W  decoded address/operand
is_long  out  1  current op is a long instruction
illegal  out  1  current op has an illegal short opcode
out_valid  out  1  op/ad/is_long/illegal valid
out_ready  in  1  consumer accepts when out_valid && out_ready

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; ext counter = 0.
  - op, ad, is_long, illegal and out_valid all go to 0.
- Opcode field: opc = in_data[DATA_W-1 -: OPC_W]. Low field: in_data[DATA_W-OPC_W-1:0].
- States: IDLE, EXT, HOLD.
- in_ready (combinational):
  - 0 when flush = 1.
  - 1 in IDLE and EXT.
  - Equal to out_ready in HOLD (pass-through acceptance, no bubble).
- Byte accept in IDLE, or in HOLD with out_ready:
  - opc == LONG_CODE:
    - op <= in_data; ad <= 0; is_long <= 0; illegal <= 0.
    - Counter <= 0; out_valid <= 0; next state EXT.
  - opc legal (LEGAL_MASK[opc]):
    - op <= {opc, zeros}; ad <= zero-extended low field.
    - is_long <= 0; illegal <= 0; out_valid <= 1; stay in or go to HOLD.
  - opc illegal:
    - op <= {opc, zeros}; ad <= 0; illegal <= 1; out_valid <= 1; HOLD.
- HOLD with out_ready && !in_valid: out_valid <= 0; next state IDLE. op/ad keep their last values.
- EXT accept:
  - ad <= {ad[AD_W-DATA_W-1:0], in_data}, i.e. first extension byte ends up most significant. When EXT_BYTES=1, ad <= in_data.
  - Counter increments.
  - On the EXT_BYTES-th byte: is_long <= 1; out_valid <= 1; HOLD.
  - Any opc value in an extension byte is data; it is never decoded.
- EXT with no in_valid: hold the counter and partial ad indefinitely.
- Latency: outputs valid on the clock edge after the final byte of an instruction is accepted.
- Stability: while out_valid && !out_ready, op/ad/is_long/illegal are stable.
- flush (synchronous, priority over all handshakes):
  - Next state IDLE; out_valid <= 0; counter <= 0.
  - op, ad, is_long and illegal are cleared to 0.
  - A byte presented in the flush cycle is not accepted (in_ready = 0).
- Counter width: $clog2(EXT_BYTES+1). It never wraps; it is cleared on entry to EXT.

Decomposition:
- The `cu_* opcode constants stay in the shared define.v. LONG_CODE and LEGAL_MASK defaults are built from them.
- Add state encodings `IRS_IDLE, `IRS_EXT and `IRS_HOLD to define.v.
- One natural sub-module: ir_ext_shift. It holds the parametrised extension shift register plus counter, with clear/shift/done.

Test Plan:
1. Reset mid-EXT:
   - Stimulus: EXT_BYTES=2; accept 0xE5, accept 0x12; assert rst.
   - Required: all outputs go to 0 immediately. Next byte 0x21 produces op=0x20, ad=0x001 one cycle after acceptance.
2. Short decode:
   - Stimulus: default params, in_data=0x47 accepted.
   - Required: next edge op=0x40, ad=0x07, out_valid=1, is_long=0. Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0.
3. Long assembly:
   - Stimulus: EXT_BYTES=2; bytes 0xE3, 0xAB, 0xCD, with 2 idle cycles between the 2nd and 3rd.
   - Required: op=0xE3, ad=0xABCD, is_long=1, out_valid=1 one cycle after 0xCD. out_valid=0 throughout EXT.
4. Back-to-back:
   - Stimulus: out_ready=1 constantly; bytes 0x21, 0x65 on consecutive cycles.
   - Required: op/ad are 0x20/0x01, then 0x60/0x05 on consecutive cycles; out_valid stays 1 with no bubble.
5. Illegal opcode:
   - Stimulus: byte 0xBF.
   - Required: op=0xA0, ad=0, illegal=1, out_valid=1. After accepting 0x05, illegal returns to 0.
6. Flush:
   - Stimulus: EXT_BYTES=1; accept 0xE0; assert flush together with in_valid and 0x33.
   - Required: in_ready=0, byte not taken, state IDLE, out_valid=0, op=0, ad=0.
